// File: rtl/int_to_fpu.sv
// Integer to 32-bit float operand encoder, one normalize shift per clock.
// Define ROUND_NEAREST_EN for round-to-nearest-even instead of truncation.
module int_to_fpu #(
  parameter int BIAS      = 511,
  parameter bit SIGNED_IN = 1'b1
) (
  input  logic        clock_100Khz,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] int_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] data_out,
  output logic [3:0]  status_out
);

  typedef enum logic [3:0] {
    OVERFLOW  = 4'd0,
    UNDERFLOW = 4'd1,
    EXACT     = 4'd2,
    INEXACT   = 4'd3
  } status_t;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] NORMALIZE = 2'd1;
  localparam logic [1:0] PACK      = 2'd2;

  logic [1:0]  state;
  logic        sign;
  logic [31:0] mag;
  logic [4:0]  cnt;
  status_t     status;

  logic        in_sign;
  logic [31:0] in_mag;
  logic [11:0] exp_raw;
  logic [11:0] exp_fin;
  logic [20:0] mant_fin;
  logic        is_zero;
  logic        ovf;
  logic [31:0] pk_data;
  status_t     pk_stat;

  assign in_sign = SIGNED_IN & int_in[31];
  assign in_mag  = in_sign ? (~int_in + 32'd1) : int_in;

  assign exp_raw = 12'(BIAS) + 12'd31 - {7'd0, cnt};
  assign is_zero = (mag == 32'd0);

`ifdef ROUND_NEAREST_EN
  logic        rnd_up;
  logic [21:0] mant_sum;

  // ties go to the even mantissa; carry-out bumps the exponent
  assign rnd_up   = mag[9] & ((|mag[8:0]) | mag[10]);
  assign mant_sum = {1'b0, mag[30:10]} + {21'd0, rnd_up};
  assign mant_fin = mant_sum[20:0];
  assign exp_fin  = exp_raw + {11'd0, mant_sum[21]};
`else
  assign mant_fin = mag[30:10];
  assign exp_fin  = exp_raw;
`endif

  assign ovf = (exp_fin >= 12'd1023);

  always_comb begin
    pk_data = {sign, exp_fin[9:0], mant_fin};
    pk_stat = EXACT;
    unique case (1'b1)
      is_zero: begin
        pk_data = 32'd0;
        pk_stat = EXACT;
      end
      ovf: begin
        pk_data = {sign, 10'h3FF, 21'h0};
        pk_stat = OVERFLOW;
      end
      default: begin
        pk_stat = (|mag[9:0]) ? INEXACT : EXACT;
      end
    endcase
  end

  assign busy       = (state != IDLE);
  assign status_out = status;

  always_ff @(posedge clock_100Khz or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      sign     <= 1'b0;
      mag      <= 32'd0;
      cnt      <= 5'd0;
      done     <= 1'b0;
      data_out <= 32'd0;
      status   <= EXACT;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign  <= in_sign;
            mag   <= in_mag;
            cnt   <= 5'd0;
            state <= (in_mag == 32'd0) ? PACK : NORMALIZE;
          end
        end
        NORMALIZE: begin
          if (mag[31]) begin
            state <= PACK;
          end else begin
            mag <= {mag[30:0], 1'b0};
            cnt <= cnt + 5'd1;
          end
        end
        PACK: begin
          data_out <= pk_data;
          status   <= pk_stat;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_fpu.sv
// Bench for int_to_fpu: directed vectors checked against a value-level model.
// Build with ROUND_NEAREST_EN defined to exercise the rounding variant.
module tb_int_to_fpu;

  logic        clock_100Khz = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] int_in = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] data_out;
  logic [3:0]  status_out;

  int_to_fpu dut (
    .clock_100Khz(clock_100Khz),
    .reset(reset),
    .start(start),
    .int_in(int_in),
    .busy(busy),
    .done(done),
    .data_out(data_out),
    .status_out(status_out)
  );

  always #5 clock_100Khz = ~clock_100Khz;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clock_100Khz) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] x;
    int          acc;
  } job_t;

  job_t q[$];
  logic [31:0] hold_d = 32'd0;
  logic [3:0]  hold_s = 4'd2;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // value-level reference: leading-one position, fraction, remainder
  function automatic void model(input logic [31:0] x,
                                output logic [31:0] d,
                                output logic [3:0] s,
                                output int lat);
    bit     sg;
    longint m, f, mant, rem, half;
    int     p, e;
    sg = x[31];
    m  = sg ? (64'h1_0000_0000 - longint'(x)) : longint'(x);
    if (m == 0) begin
      d = 32'd0; s = 4'd2; lat = 1;
      return;
    end
    p = 0;
    for (int i = 0; i < 32; i++)
      if (m >= (longint'(1) << i)) p = i;
    lat = 31 - p + 2;
    e   = 511 + p;
    f   = m - (longint'(1) << p);
    if (p > 21) begin
      mant = f >> (p - 21);
      rem  = f - (mant << (p - 21));
      half = longint'(1) << (p - 22);
    end else begin
      mant = f << (21 - p);
      rem  = 0;
      half = 0;
    end
    s = (rem != 0) ? 4'd3 : 4'd2;
`ifdef ROUND_NEAREST_EN
    if (rem != 0 && (rem > half || (rem == half && mant % 2 == 1)))
      mant = mant + 1;
    if (mant == (longint'(1) << 21)) begin
      mant = 0;
      e    = e + 1;
    end
`endif
    if (e >= 1023) begin
      d = {sg, 10'h3FF, 21'h0};
      s = 4'd0;
    end else begin
      d = {sg, 10'(e), 21'(mant)};
    end
  endfunction

  always @(negedge clock_100Khz) begin
    job_t        j;
    logic [31:0] d;
    logic [3:0]  s;
    int          l;
    chk("busy", {31'd0, busy}, {31'd0, (q.size() > 0 && !done)});
    if (done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 want 0");
      end else begin
        j = q.pop_front();
        model(j.x, d, s, l);
        chk("data", data_out, d);
        chk("status", {28'd0, status_out}, {28'd0, s});
        chk("latency", 32'(cyc - j.acc), 32'(l));
        hold_d = d;
        hold_s = s;
      end
    end else begin
      chk("hold_data", data_out, hold_d);
      chk("hold_status", {28'd0, status_out}, {28'd0, hold_s});
    end
  end

  task automatic issue(input logic [31:0] x, input bit track);
    @(negedge clock_100Khz);
    #1;
    start  = 1'b1;
    int_in = x;
    @(posedge clock_100Khz);
    #1;
    start  = 1'b0;
    int_in = $urandom;
    if (track) q.push_back('{x, cyc});
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() > 0 && n < 80) begin
      @(negedge clock_100Khz);
      n++;
    end
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL timeout: pending %0d want 0", q.size());
      q.delete();
    end
  endtask

  task automatic pin(input logic [31:0] x, input logic [31:0] ed,
                     input logic [3:0] es, input int el);
    logic [31:0] d;
    logic [3:0]  s;
    int          l;
    model(x, d, s, l);
    chk("model_data", d, ed);
    chk("model_status", {28'd0, s}, {28'd0, es});
    chk("model_latency", 32'(l), 32'(el));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  logic [31:0] vec [0:8];

  initial begin
    repeat (3) @(negedge clock_100Khz);
    chk("rst_data", data_out, 32'd0);
    chk("rst_status", {28'd0, status_out}, 32'd2);
    chk("rst_done", {31'd0, done}, 32'd0);
    #1;
    reset = 1'b1;

    pin(32'h0000_0001, 32'h3FE0_0000, 4'd2, 33);
    pin(32'hFFFF_FFFD, 32'hC010_0000, 4'd2, 32);
    pin(32'h0000_0000, 32'h0000_0000, 4'd2, 1);
    pin(32'h8000_0000, 32'hC3C0_0000, 4'd2, 2);
    pin(32'h0000_0002, 32'h4000_0000, 4'd2, 32);
    pin(32'hFFFF_FFFF, 32'hBFE0_0000, 4'd2, 33);
`ifdef ROUND_NEAREST_EN
    pin(32'h7FFF_FFFF, 32'h43C0_0000, 4'd3, 3);
`else
    pin(32'h7FFF_FFFF, 32'h43BF_FFFF, 4'd3, 3);
`endif

    vec[0] = 32'h0000_0001;
    vec[1] = 32'hFFFF_FFFD;
    vec[2] = 32'h0000_0000;
    vec[3] = 32'h7FFF_FFFF;
    vec[4] = 32'h8000_0000;
    vec[5] = 32'h0020_0001;
    vec[6] = 32'h0060_0600;
    vec[7] = 32'h1234_5678;
    vec[8] = 32'hFFC0_0001;
    foreach (vec[i]) begin
      issue(vec[i], 1'b1);
      wait_idle();
    end

    repeat (6) begin
      issue($urandom, 1'b1);
      wait_idle();
    end

    issue(32'h0000_0001, 1'b1);
    repeat (9) @(negedge clock_100Khz);
    issue(32'h0000_0005, 1'b0);
    wait_idle();
    repeat (4) @(negedge clock_100Khz);

    issue(32'h0000_0001, 1'b1);
    repeat (9) @(negedge clock_100Khz);
    #1;
    reset  = 1'b0;
    q.delete();
    hold_d = 32'd0;
    hold_s = 4'd2;
    repeat (2) @(negedge clock_100Khz);
    chk("abort_data", data_out, 32'd0);
    chk("abort_status", {28'd0, status_out}, 32'd2);
    #1;
    reset = 1'b1;
    repeat (40) @(negedge clock_100Khz);

    issue(32'h0000_0002, 1'b1);
    wait_idle();
    chk("after_reset", data_out, 32'h4000_0000);

    repeat (2) @(negedge clock_100Khz);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
